// File: rtl/code_packer_pkg.sv
// Shared types and helpers for the variable-length code packer.
package code_packer_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_type;

  // Accumulator width: one full packet plus the longest code that can land on top of it.
  function automatic int acc_width(input int packet_w, input int max_code_w);
    return packet_w + max_code_w;
  endfunction

  function automatic int clamp_len(input int len, input int max_code_w);
    return (len > max_code_w) ? max_code_w : len;
  endfunction

endpackage

// File: rtl/packer_shift_acc.sv
// Left-aligned bit accumulator: pops a packet from the top, inserts codes just below the valid bits.
module packer_shift_acc
  import code_packer_pkg::*;
#(
  parameter int PACKET_W   = 8,
  parameter int MAX_CODE_W = 16,
  parameter int LEN_W      = $clog2(MAX_CODE_W + 1),
  localparam int ACC_W     = acc_width(PACKET_W, MAX_CODE_W),
  localparam int CW        = $clog2(ACC_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [MAX_CODE_W-1:0] code_bits,
  input  logic [LEN_W-1:0]      code_len,
  output logic [PACKET_W-1:0]   head,
  output logic [CW-1:0]         cnt,
  output logic                  full,
  output logic                  empty
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_pop;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] code_mask;
  logic [CW-1:0]    cnt_pop;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    shamt;

  assign head  = acc[ACC_W-1 -: PACKET_W];
  assign full  = (cnt >= CW'(PACKET_W));
  assign empty = (cnt == '0);

  always_comb begin
    acc_pop = acc;
    cnt_pop = cnt;
    if (pop) begin
      acc_pop = acc << PACKET_W;
      cnt_pop = full ? (cnt - CW'(PACKET_W)) : '0;
    end

    code_mask = '0;
    for (int i = 0; i < MAX_CODE_W; i++) begin
      if (LEN_W'(i) < code_len) code_mask[i] = code_bits[i];
    end

    // The code's LSB lands ACC_W - (cnt + len) bits up from the accumulator LSB.
    shamt    = CW'(ACC_W) - cnt_pop - CW'(code_len);
    acc_next = acc_pop;
    cnt_next = cnt_pop;
    if (push) begin
      acc_next = acc_pop | (code_mask << shamt);
      cnt_next = cnt_pop + CW'(code_len);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/code_packer.sv
// Variable-length code packer: RUN/FLUSH control, handshakes, flush pulse and packet counter.
module code_packer
  import code_packer_pkg::*;
#(
  parameter int PACKET_W   = 8,
  parameter int MAX_CODE_W = 16,
  parameter int LEN_W      = $clog2(MAX_CODE_W + 1),
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            code_valid,
  output logic                            code_ready,
  input  logic [MAX_CODE_W-1:0]           code_bits,
  input  logic [LEN_W-1:0]                code_len,
  input  logic                            code_last,
  output logic                            packet_valid,
  input  logic                            packet_ready,
  output logic [PACKET_W-1:0]             packet_data,
  output logic                            packet_last,
  output logic [$clog2(PACKET_W+1)-1:0]   packet_pad,
  output logic                            flush_done,
  output logic [CNT_W-1:0]                packet_cnt
);

  localparam int ACC_W = acc_width(PACKET_W, MAX_CODE_W);
  localparam int CW    = $clog2(ACC_W + 1);
  localparam int PAD_W = $clog2(PACKET_W + 1);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid/data hold until accepted, and every ready/valid here is decoded from registers only.
  state_type        state;
  state_type        state_next;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             flush_done_next;
  logic [LEN_W-1:0] len_c;
  logic [CW-1:0]    pad_full;

  assign len_c        = LEN_W'(clamp_len(int'(code_len), MAX_CODE_W));
  assign code_ready   = (state == RUN) && (cnt <= CW'(PACKET_W));
  assign packet_valid = full || ((state == FLUSH) && !empty);
  assign packet_last  = (state == FLUSH) && !empty && (cnt <= CW'(PACKET_W));
  assign pad_full     = CW'(PACKET_W) - cnt;
  assign packet_pad   = packet_last ? PAD_W'(pad_full) : '0;
  assign push         = code_valid && code_ready;
  assign pop          = packet_valid && packet_ready;

  packer_shift_acc #(
    .PACKET_W  (PACKET_W),
    .MAX_CODE_W(MAX_CODE_W),
    .LEN_W     (LEN_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .code_bits(code_bits),
    .code_len (len_c),
    .head     (packet_data),
    .cnt      (cnt),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (push && code_last) state_next = FLUSH;
      FLUSH:   if (empty || (pop && packet_last)) state_next = RUN;
      default: state_next = RUN;
    endcase
    flush_done_next = (state == FLUSH) && (state_next == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      flush_done <= 1'b0;
      packet_cnt <= '0;
    end else begin
      state      <= state_next;
      flush_done <= flush_done_next;
      if (pop) packet_cnt <= packet_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_code_packer.sv
// Directed bench for code_packer (PACKET_W=8, MAX_CODE_W=16) with an expected-packet scoreboard.
module tb_code_packer;
  import code_packer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        code_valid;
  logic        code_ready;
  logic [15:0] code_bits;
  logic [4:0]  code_len;
  logic        code_last;
  logic        packet_valid;
  logic        packet_ready;
  logic [7:0]  packet_data;
  logic        packet_last;
  logic [3:0]  packet_pad;
  logic        flush_done;
  logic [15:0] packet_cnt;

  // Expected packet entry: {last, pad[3:0], data[7:0]}
  logic [12:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int flush_seen = 0;

  code_packer #(
    .PACKET_W  (8),
    .MAX_CODE_W(16),
    .LEN_W     (5),
    .CNT_W     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .code_bits   (code_bits),
    .code_len    (code_len),
    .code_last   (code_last),
    .packet_valid(packet_valid),
    .packet_ready(packet_ready),
    .packet_data (packet_data),
    .packet_last (packet_last),
    .packet_pad  (packet_pad),
    .flush_done  (flush_done),
    .packet_cnt  (packet_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] pkt(input logic last, input logic [3:0] pad, input logic [7:0] data);
    return {last, pad, data};
  endfunction

  // scoreboard: a handshake seen at negedge completes at the following posedge
  always @(negedge clk) begin
    if (!rst) begin
      if (flush_done) flush_seen++;
      if (packet_valid && packet_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pkt", {24'd0, packet_data}, 32'hFFFF_FFFF);
        end else begin
          logic [12:0] e;
          e = exp_q.pop_front();
          check("pkt_data", {24'd0, packet_data}, {24'd0, e[7:0]});
          check("pkt_last", {31'd0, packet_last}, {31'd0, e[12]});
          check("pkt_pad", {28'd0, packet_pad}, {28'd0, e[11:8]});
        end
      end
    end
  end

  // driver tasks (caller sits just after a posedge)
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_code(input logic [15:0] bits, input logic [4:0] len, input logic last);
    int n;
    n = 0;
    code_valid = 1'b1;
    code_bits  = bits;
    code_len   = len;
    code_last  = last;
    forever begin
      @(negedge clk);
      if (code_ready) break;
      n++;
      if (n > 50) begin
        check("push_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    code_bits  = '0;
    code_len   = '0;
    code_last  = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    code_valid   = 1'b0;
    code_bits    = '0;
    code_len     = '0;
    code_last    = 1'b0;
    packet_ready = 1'b0;
    cycles(2);
    check("rst_code_ready", {31'd0, code_ready}, 32'd1);
    check("rst_packet_valid", {31'd0, packet_valid}, 32'd0);
    check("rst_packet_cnt", {16'd0, packet_cnt}, 32'd0);
    check("rst_packet_data", {24'd0, packet_data}, 32'd0);
    check("rst_packet_last", {31'd0, packet_last}, 32'd0);
    check("rst_packet_pad", {28'd0, packet_pad}, 32'd0);
    check("rst_flush_done", {31'd0, flush_done}, 32'd0);
    rst = 1'b0;
    cycles(1);

    // basic packing: 101 + 11001 -> B9
    packet_ready = 1'b1;
    exp_q.push_back(pkt(1'b0, 4'd0, 8'hB9));
    push_code(16'h0005, 5'd3, 1'b0);
    push_code(16'h0019, 5'd5, 1'b0);
    cycles(3);
    check("basic_packet_cnt", {16'd0, packet_cnt}, 32'd1);
    check("basic_cnt", 32'(dut.u_acc.cnt), 32'd0);

    // zero-length code is a no-op
    push_code(16'hFFFF, 5'd0, 1'b0);
    cycles(1);
    check("len0_cnt", 32'(dut.u_acc.cnt), 32'd0);
    check("len0_valid", {31'd0, packet_valid}, 32'd0);

    // long code: 1111 + ABCD -> FA, BC, leaving 1101
    exp_q.push_back(pkt(1'b0, 4'd0, 8'hFA));
    exp_q.push_back(pkt(1'b0, 4'd0, 8'hBC));
    push_code(16'h000F, 5'd4, 1'b0);
    push_code(16'hABCD, 5'd16, 1'b0);
    check("full20_cnt", 32'(dut.u_acc.cnt), 32'd20);
    check("full20_ready", {31'd0, code_ready}, 32'd0);
    cycles(1);
    check("full12_cnt", 32'(dut.u_acc.cnt), 32'd12);
    check("full12_ready", {31'd0, code_ready}, 32'd0);
    cycles(1);
    check("full4_cnt", 32'(dut.u_acc.cnt), 32'd4);
    check("full4_ready", {31'd0, code_ready}, 32'd1);
    // drain the leftover 1101 with four zero bits -> D0
    exp_q.push_back(pkt(1'b0, 4'd0, 8'hD0));
    push_code(16'h0000, 5'd4, 1'b0);
    cycles(3);

    // flush: 101 last -> A0, last, pad 5
    exp_q.push_back(pkt(1'b1, 4'd5, 8'hA0));
    push_code(16'h0005, 5'd3, 1'b1);
    check("flush_state", {31'd0, dut.state}, {31'd0, FLUSH});
    check("flush_ready", {31'd0, code_ready}, 32'd0);
    cycles(1);
    check("flush_back_run", {31'd0, dut.state}, {31'd0, RUN});
    check("flush_done_pulse", {31'd0, flush_done}, 32'd1);
    check("flush_run_ready", {31'd0, code_ready}, 32'd1);
    cycles(2);
    check("flush_done_once", 32'(flush_seen), 32'd1);

    // backpressure: C3 held for 5 cycles while 10110 queues behind it
    packet_ready = 1'b0;
    exp_q.push_back(pkt(1'b0, 4'd0, 8'hC3));
    exp_q.push_back(pkt(1'b0, 4'd0, 8'hB2));
    exp_q.push_back(pkt(1'b0, 4'd0, 8'hD7));
    push_code(16'h00C3, 5'd8, 1'b0);
    push_code(16'h0016, 5'd5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_data", {24'd0, packet_data}, 32'hC3);
      check("bp_valid", {31'd0, packet_valid}, 32'd1);
      check("bp_ready", {31'd0, code_ready}, 32'd0);
      cycles(1);
    end
    packet_ready = 1'b1;
    push_code(16'h005A, 5'd8, 1'b0);
    push_code(16'h0007, 5'd3, 1'b0);
    cycles(3);
    check("bp_cnt", 32'(dut.u_acc.cnt), 32'd0);

    // oversize length is clamped to 16 bits -> FF, FF
    exp_q.push_back(pkt(1'b0, 4'd0, 8'hFF));
    exp_q.push_back(pkt(1'b0, 4'd0, 8'hFF));
    push_code(16'hFFFF, 5'd20, 1'b0);
    cycles(3);
    check("clamp_cnt", 32'(dut.u_acc.cnt), 32'd0);
    check("total_packet_cnt", {16'd0, packet_cnt}, 32'd10);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // reset in FLUSH with a packet pending: 110011 last -> CC, pad 2, then dropped
    packet_ready = 1'b0;
    push_code(16'h0033, 5'd6, 1'b1);
    check("mid_state", {31'd0, dut.state}, {31'd0, FLUSH});
    check("mid_valid", {31'd0, packet_valid}, 32'd1);
    check("mid_data", {24'd0, packet_data}, 32'hCC);
    check("mid_last", {31'd0, packet_last}, 32'd1);
    check("mid_pad", {28'd0, packet_pad}, 32'd2);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("mrst_valid", {31'd0, packet_valid}, 32'd0);
    check("mrst_cnt", 32'(dut.u_acc.cnt), 32'd0);
    check("mrst_state", {31'd0, dut.state}, {31'd0, RUN});
    check("mrst_ready", {31'd0, code_ready}, 32'd1);
    check("mrst_packet_cnt", {16'd0, packet_cnt}, 32'd0);
    packet_ready = 1'b1;
    cycles(4);
    check("mrst_no_flush_done", 32'(flush_seen), 32'd1);
    check("mrst_no_packets", {16'd0, packet_cnt}, 32'd0);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
